multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_if.sv | 26 ++
 rtl/multicycle_ctrl_alu_dec.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle controller.
//   state_t  - FSM state encoding (also exported on state_o)
//   aluop_t  - internal ALU operation class handed to alu_dec
//   OP_*/F_* - opcode / funct constants (6-bit instruction fields)
//   ALU_*    - 3-bit ALUControl encodings
//   SRCB_*/PCSRC_*/REGDST_*/MTR_* - datapath mux select encodings
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_AND, AOP_OR, AOP_SLT
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BOFF = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_REG = 2'b11;
  localparam logic [1:0] REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10;
  localparam logic [1:0] MTR_ALU = 2'b00, MTR_MEM = 2'b01, MTR_PC = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshake and datapath controls.
//   master - instruction/memory side (drives Opcode, Funct, mem_ready)
//   slave  - controller side (drives all strobes, selects, IllegalOp, state_o)
interface multicycle_ctrl_if #(
  parameter int ALUC_W = 3,
  parameter int OP_W   = 6
);
  logic [OP_W-1:0]   Opcode, Funct;
  logic              mem_ready;
  logic              IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch, BranchNe;
  logic [ALUC_W-1:0] ALUControl;
  logic [1:0]        ALUSrcB, PCSrc, MemtoReg, RegDst;
  logic              IllegalOp;
  logic [3:0]        state_o;

  modport master (
    output Opcode, Funct, mem_ready,
    input  IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch, BranchNe,
    input  ALUControl, ALUSrcB, PCSrc, MemtoReg, RegDst, IllegalOp, state_o
  );
  modport slave (
    input  Opcode, Funct, mem_ready,
    output IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch, BranchNe,
    output ALUControl, ALUSrcB, PCSrc, MemtoReg, RegDst, IllegalOp, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// alu_dec: maps ALU operation class + latched funct to the 3-bit ALUControl code.
//   aluop    - operation class chosen by the FSM
//   funct    - latched instruction funct field
//   code     - ALUControl encoding
//   funct_ok - funct is one of the supported R-type operations (independent of aluop)
module alu_dec
  import ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  aluop_t          aluop,
  input  logic [OP_W-1:0] funct,
  output logic [2:0]      code,
  output logic            funct_ok
);
  logic [2:0] fcode;

  always_comb begin
    fcode    = ALU_AND;
    funct_ok = 1'b1;
    case (funct)
      OP_W'(F_ADD): fcode = ALU_ADD;
      OP_W'(F_SUB): fcode = ALU_SUB;
      OP_W'(F_AND): fcode = ALU_AND;
      OP_W'(F_OR):  fcode = ALU_OR;
      OP_W'(F_SLT): fcode = ALU_SLT;
      default:      funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    code = fcode;
    case (aluop)
      AOP_ADD: code = ALU_ADD;
      AOP_SUB: code = ALU_SUB;
      AOP_AND: code = ALU_AND;
      AOP_OR:  code = ALU_OR;
      AOP_SLT: code = ALU_SLT;
      default: code = fcode;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle MIPS-style datapath.
//   clk - clock, rst - asynchronous active-low reset
//   bus - multicycle_ctrl_if.slave (instruction fields, mem_ready, datapath controls)
// Optional feature: define CTRL_JAL_EN to build the JAL and JR states; otherwise
// those codes raise IllegalOp.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALUC_W = 3,
  parameter int OP_W   = 6
) (
  input logic            clk,
  input logic            rst,
  multicycle_ctrl_if.slave bus
);
  state_t          state, dec_nxt;
  logic [OP_W-1:0] op_q, fn_q;
  logic            ill_q, dec_ok, fn_ok, alu_en;
  aluop_t          aluop;
  logic [2:0]      alu_code;

  alu_dec #(.OP_W(OP_W)) u_alu_dec (
    .aluop(aluop), .funct(fn_q), .code(alu_code), .funct_ok(fn_ok)
  );

  // DECODE dispatch on the live instruction fields (latched on the same edge).
  always_comb begin
    dec_nxt = S_FETCH;
    dec_ok  = 1'b1;
    case (bus.Opcode)
      OP_W'(OP_LW), OP_W'(OP_SW): dec_nxt = S_MEMADR;
      OP_W'(OP_RTYPE): begin
`ifdef CTRL_JAL_EN
        dec_nxt = (bus.Funct == OP_W'(F_JR)) ? S_JR : S_EXEC;
`else
        dec_nxt = S_EXEC;
`endif
      end
      OP_W'(OP_BEQ), OP_W'(OP_BNE): dec_nxt = S_BRANCH;
      OP_W'(OP_ADDI), OP_W'(OP_ANDI), OP_W'(OP_ORI), OP_W'(OP_SLTI): dec_nxt = S_IMMEX;
      OP_W'(OP_J): dec_nxt = S_JUMP;
`ifdef CTRL_JAL_EN
      OP_W'(OP_JAL): dec_nxt = S_JAL;
`endif
      default: dec_ok = 1'b0;
    endcase
  end

  // IllegalOp is registered so it shows for exactly the one FETCH cycle after
  // the offending DECODE/EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      op_q  <= '0;
      fn_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      case (state)
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q  <= bus.Opcode;
          fn_q  <= bus.Funct;
          state <= dec_nxt;
          ill_q <= !dec_ok;
        end
        S_MEMADR: state <= (op_q == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        S_EXEC: begin
          state <= fn_ok ? S_ALUWB : S_FETCH;
          ill_q <= !fn_ok;
        end
        S_IMMEX:  state <= S_IMMWB;
        default:  state <= S_FETCH;  // write-back/jump states and unreachable codes
      endcase
    end
  end

  always_comb begin
    bus.IorD     = 1'b0; bus.ALUSrcA  = 1'b0; bus.IRWrite  = 1'b0;
    bus.MemWrite = 1'b0; bus.PCWrite  = 1'b0; bus.RegWrite = 1'b0;
    bus.Ori      = 1'b0; bus.Branch   = 1'b0; bus.BranchNe = 1'b0;
    bus.ALUSrcB  = SRCB_REG;  bus.PCSrc  = PCSRC_ALU;
    bus.MemtoReg = MTR_ALU;   bus.RegDst = REGDST_RT;
    aluop        = AOP_ADD;
    alu_en       = 1'b0;
    case (state)
      S_FETCH: begin
        bus.ALUSrcB = SRCB_FOUR;
        alu_en      = 1'b1;
        // the fetch only completes with the memory; rst gating keeps strobes
        // low while held in reset
        bus.IRWrite = bus.mem_ready & rst;
        bus.PCWrite = bus.mem_ready & rst;
      end
      S_DECODE: begin bus.ALUSrcB = SRCB_BOFF; alu_en = 1'b1; end
      S_MEMADR: begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = SRCB_IMM; alu_en = 1'b1; end
      S_MEMRD:  bus.IorD = 1'b1;
      S_MEMWB:  begin bus.MemtoReg = MTR_MEM; bus.RegWrite = 1'b1; end
      S_MEMWR:  begin bus.IorD = 1'b1; bus.MemWrite = 1'b1; end
      S_EXEC:   begin bus.ALUSrcA = 1'b1; aluop = AOP_FUNCT; alu_en = 1'b1; end
      S_ALUWB:  begin bus.RegDst = REGDST_RD; bus.RegWrite = 1'b1; end
      S_BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        aluop        = AOP_SUB;
        alu_en       = 1'b1;
        bus.PCSrc    = PCSRC_ALUOUT;
        bus.Branch   = (op_q == OP_W'(OP_BEQ));
        bus.BranchNe = (op_q == OP_W'(OP_BNE));
      end
      S_IMMEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        alu_en      = 1'b1;
        if (op_q == OP_W'(OP_ANDI))      aluop = AOP_AND;
        else if (op_q == OP_W'(OP_ORI))  aluop = AOP_OR;
        else if (op_q == OP_W'(OP_SLTI)) aluop = AOP_SLT;
        bus.Ori = (op_q == OP_W'(OP_ANDI)) || (op_q == OP_W'(OP_ORI));
      end
      S_IMMWB: bus.RegWrite = 1'b1;
      S_JUMP:  begin bus.PCSrc = PCSRC_JUMP; bus.PCWrite = 1'b1; end
`ifdef CTRL_JAL_EN
      S_JR:    begin bus.PCSrc = PCSRC_REG; bus.PCWrite = 1'b1; end
      S_JAL: begin
        bus.RegDst   = REGDST_RA;
        bus.MemtoReg = MTR_PC;
        bus.RegWrite = 1'b1;
        bus.PCSrc    = PCSRC_JUMP;
        bus.PCWrite  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.ALUControl = alu_en ? ALUC_W'(alu_code) : '0;
  assign bus.IllegalOp  = ill_q;
  assign bus.state_o    = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALUC_W(3), .OP_W(6)) bus ();
  multicycle_ctrl #(.ALUC_W(3), .OP_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic iord, srca, irw, memw, pcw, regw, ori, br, bne;
    logic [2:0] aluc;
    logic [1:0] srcb, pcsrc, mtr, regdst;
    logic ill;
  } obs_t;

  typedef struct {
    logic mr;
    bit   dec;
    logic [5:0] op, fn;
    obs_t e;
  } step_t;

  step_t q[$];
  int n_assert = 0, n_fail = 0;
  bit ill_pend = 0;

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state_o; o.iord = bus.IorD; o.srca = bus.ALUSrcA; o.irw = bus.IRWrite;
    o.memw = bus.MemWrite; o.pcw = bus.PCWrite; o.regw = bus.RegWrite; o.ori = bus.Ori;
    o.br = bus.Branch; o.bne = bus.BranchNe; o.aluc = bus.ALUControl; o.srcb = bus.ALUSrcB;
    o.pcsrc = bus.PCSrc; o.mtr = bus.MemtoReg; o.regdst = bus.RegDst; o.ill = bus.IllegalOp;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t fetch_o();
    obs_t o = '0;
    o.st = S_FETCH; o.srcb = 2'b01; o.aluc = 3'b010;
    return o;
  endfunction

  function automatic obs_t ex_o(input logic [3:0] st);
    obs_t o = '0;
    o.st = st; o.srca = 1'b1;
    return o;
  endfunction

  function automatic void push(input logic mr, input bit dec, input logic [5:0] op, fn, input obs_t e);
    step_t s;
    s.mr = mr; s.dec = dec; s.op = op; s.fn = fn; s.e = e;
    q.push_back(s);
  endfunction

  // R-type funct table: ALU code and whether the funct is supported
  function automatic void r_alu(input logic [5:0] fn, output logic [2:0] ac, output bit ok);
    ok = 1'b1;
    case (fn)
      6'b100000: ac = 3'b010;
      6'b100010: ac = 3'b110;
      6'b100100: ac = 3'b000;
      6'b100101: ac = 3'b001;
      6'b101010: ac = 3'b111;
      default: begin ac = 3'b000; ok = 1'b0; end
    endcase
  endfunction

  // Expected per-cycle trace of one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic build(input logic [5:0] op, fn, input int fw, mw);
    obs_t o;
    logic [2:0] ac;
    bit ok;
    logic rnd;
    for (int i = 0; i <= fw; i++) begin
      o = fetch_o(); o.irw = (i == fw); o.pcw = (i == fw); o.ill = (i == 0) && ill_pend;
      push(i == fw, 0, op, fn, o);
    end
    ill_pend = 0;
    rnd = 1'($urandom);
    o = '0; o.st = S_DECODE; o.srcb = 2'b11; o.aluc = 3'b010;
    push(rnd, 1, op, fn, o);
    if (op == 6'b100011 || op == 6'b101011) begin
      o = ex_o(S_MEMADR); o.srcb = 2'b10; o.aluc = 3'b010; push(1'($urandom), 0, op, fn, o);
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.iord = 1'b1;
        o.st = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
        o.memw = (op == 6'b101011);
        push(i == mw, 0, op, fn, o);
      end
      if (op == 6'b100011) begin
        o = '0; o.st = S_MEMWB; o.mtr = 2'b01; o.regw = 1'b1; push(1'($urandom), 0, op, fn, o);
      end
    end else if (op == 6'b000000 && JAL_EN && fn == 6'b001000) begin
      o = '0; o.st = S_JR; o.pcsrc = 2'b11; o.pcw = 1'b1; push(1'($urandom), 0, op, fn, o);
    end else if (op == 6'b000000) begin
      r_alu(fn, ac, ok);
      o = ex_o(S_EXEC); o.aluc = ac; push(1'($urandom), 0, op, fn, o);
      if (ok) begin
        o = '0; o.st = S_ALUWB; o.regdst = 2'b01; o.regw = 1'b1; push(1'($urandom), 0, op, fn, o);
      end else ill_pend = 1;
    end else if (op == 6'b000100 || op == 6'b000101) begin
      o = ex_o(S_BRANCH); o.aluc = 3'b110; o.pcsrc = 2'b01;
      o.br = (op == 6'b000100); o.bne = (op == 6'b000101);
      push(1'($urandom), 0, op, fn, o);
    end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010) begin
      o = ex_o(S_IMMEX); o.srcb = 2'b10;
      o.aluc = (op == 6'b001000) ? 3'b010 : (op == 6'b001100) ? 3'b000 :
               (op == 6'b001101) ? 3'b001 : 3'b111;
      o.ori = (op == 6'b001100 || op == 6'b001101);
      push(1'($urandom), 0, op, fn, o);
      o = '0; o.st = S_IMMWB; o.regw = 1'b1; push(1'($urandom), 0, op, fn, o);
    end else if (op == 6'b000010) begin
      o = '0; o.st = S_JUMP; o.pcsrc = 2'b10; o.pcw = 1'b1; push(1'($urandom), 0, op, fn, o);
    end else if (op == 6'b000011 && JAL_EN) begin
      o = '0; o.st = S_JAL; o.regdst = 2'b10; o.mtr = 2'b10; o.regw = 1'b1;
      o.pcsrc = 2'b10; o.pcw = 1'b1; push(1'($urandom), 0, op, fn, o);
    end else begin
      ill_pend = 1;
    end
  endtask

  // Play queued steps; stop after 'limit' steps (negative = all).
  task automatic run(input int limit);
    step_t s;
    int n = 0;
    while (q.size() > 0) begin
      if (n == limit) begin q.delete(); break; end
      s = q.pop_front();
      @(negedge clk);
      bus.mem_ready = s.mr;
      bus.Opcode = s.dec ? s.op : 6'($urandom);
      bus.Funct  = s.dec ? s.fn : 6'($urandom);
      #1;
      check($sformatf("step%0d_op%b_fn%b", n, s.op, s.fn), sample(), s.e);
      n++;
    end
  endtask

  logic [5:0] dops [12] = '{6'b100011, 6'b000000, 6'b000101, 6'b111111, 6'b000011, 6'b000000,
                            6'b000000, 6'b101011, 6'b000100, 6'b001101, 6'b001010, 6'b000010};
  logic [5:0] dfns [12] = '{6'b000000, 6'b100010, 6'b000000, 6'b000000, 6'b000000, 6'b001000,
                            6'b000111, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
  logic [5:0] lops [13] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
                            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b000011, 6'b000000};
  logic [5:0] lfns [7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000, 6'b000000};

  initial begin
    logic [5:0] op, fn;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.Opcode = '0;
    bus.Funct = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("reset_hold", sample(), fetch_o());
    end
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1 check("reset_release", sample(), fetch_o());

    // directed: lw with 2 memory waits, sub, bne, illegal, jal, jr, bad funct, ...
    for (int i = 0; i < 12; i++) begin
      build(dops[i], dfns[i], (i == 7) ? 2 : 0, (i == 0) ? 2 : 1);
      run(-1);
    end

    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : lops[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : lfns[$urandom_range(0, 6)];
      build(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      run(-1);
    end

    // abort a store in the middle of its memory wait
    build(6'b101011, 6'b000000, 0, 3);
    run(5);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_abort", sample(), fetch_o());
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("reset_abort_hold", sample(), fetch_o());
    end
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    ill_pend = 0;
    #1 check("reset_abort_release", sample(), fetch_o());
    build(6'b100011, 6'b000000, 0, 1);
    run(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
